// File: rtl/axi4_mem_pkg.sv
// Shared types, response codes and burst address arithmetic for the AXI4 memory responder.
package axi4_mem_pkg;

  localparam int unsigned MAX_AW = 64;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  // Address of the beat following addr; the reserved encoding falls through to INCR.
  function automatic logic [MAX_AW-1:0] next_addr(input logic [MAX_AW-1:0] addr,
                                                  input logic [7:0]        len,
                                                  input logic [2:0]        size,
                                                  input logic [1:0]        burst);
    logic [MAX_AW-1:0] incr;
    logic [MAX_AW-1:0] mask;
    incr = MAX_AW'(1) << size;
    mask = ((MAX_AW'(len) + MAX_AW'(1)) << size) - MAX_AW'(1);
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = (addr & ~mask) | ((addr + incr) & mask);
      default: next_addr = addr + incr;
    endcase
  endfunction

  // Highest byte-lane base address any beat of the burst can reach.
  function automatic logic [MAX_AW-1:0] burst_hi(input logic [MAX_AW-1:0] addr,
                                                 input logic [7:0]        len,
                                                 input logic [2:0]        size,
                                                 input logic [1:0]        burst);
    logic [MAX_AW-1:0] mask;
    mask = ((MAX_AW'(len) + MAX_AW'(1)) << size) - MAX_AW'(1);
    case (burst)
      FIXED:   burst_hi = addr;
      WRAP:    burst_hi = addr | mask;
      default: burst_hi = addr + (MAX_AW'(len) << size);
    endcase
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle (AW/W/B/AR/R); modport s is the responder view.
interface axi4_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned IW = 12
);
  logic            aclk;
  logic            aresetn;

  logic [IW-1:0]   awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [IW-1:0]   arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport s (
    input  aclk, aresetn,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_burst_addr.sv
// Registered burst address and beat generator: load captures the request, step advances one beat.
module axi4_burst_addr
  import axi4_mem_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_len,
  input  logic [2:0]    i_size,
  input  logic [1:0]    i_burst,
  input  logic          i_step,
  output logic [AW-1:0] o_addr,
  output logic [AW-1:0] o_next_addr_c,
  output logic          o_last,
  output logic          o_next_last_c
);

  logic [AW-1:0] r_addr;
  logic [7:0]    r_len;
  logic [7:0]    r_beat;
  logic [2:0]    r_size;
  logic [1:0]    r_burst;
  logic          r_last;

  assign o_next_addr_c = AW'(next_addr(MAX_AW'(r_addr), r_len, r_size, r_burst));
  assign o_next_last_c = (r_beat + 8'd1) == r_len;
  assign o_addr        = r_addr;
  assign o_last        = r_last;

  // Beat counter freezes on the last beat so len=255 never wraps it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_len   <= i_len;
      r_beat  <= '0;
      r_size  <= i_size;
      r_burst <= i_burst;
      r_last  <= (i_len == 8'd0);
    end else if (i_step && !r_last) begin
      r_addr  <= o_next_addr_c;
      r_beat  <= r_beat + 8'd1;
      r_last  <= o_next_last_c;
    end
  end

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 responder over a word-addressed memory, independent write and read engines.
// Define AXI4_MEM_SLAVE_ERR_EN to flag out-of-range / oversized bursts instead of wrapping.
module axi4_mem_slave
  import axi4_mem_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned IW    = 12,
  parameter int unsigned DEPTH = 1024
) (
  input logic clk_i,
  input logic rst_i,
  axi4_if.s   axi_s
);

  localparam int unsigned STRBW = DW / 8;
  localparam int unsigned OFFW  = $clog2(STRBW);
  localparam int unsigned IDXW  = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];

  wstate_t       r_wstate, w_wstate_nxt;
  logic          r_awready, r_wready, r_bvalid;
  logic [IW-1:0] r_bid;
  logic [1:0]    r_bresp, w_bresp_nxt;
  logic          r_wlast_err, w_beat_mismatch;
  logic [1:0]    r_w_err, w_aw_err;

  rstate_t       r_rstate, w_rstate_nxt;
  logic          r_arready, r_rvalid, r_rlast;
  logic [IW-1:0] r_rid;
  logic [1:0]    r_rresp;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_r_err, w_ar_err;

  logic          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic [AW-1:0] w_waddr, w_wnext_addr, w_raddr, w_rnext_addr;
  logic          w_wlast_gen, w_wnext_last, w_rlast_gen, w_rnext_last;
  logic          w_mem_we;
  logic          w_unused;

  assign w_aw_hs = axi_s.awvalid && r_awready;
  assign w_w_hs  = axi_s.wvalid  && r_wready;
  assign w_b_hs  = r_bvalid      && axi_s.bready;
  assign w_ar_hs = axi_s.arvalid && r_arready;
  assign w_r_hs  = r_rvalid      && axi_s.rready;

`ifdef AXI4_MEM_SLAVE_ERR_EN
  localparam logic [MAX_AW-1:0] MEM_BYTES = MAX_AW'(DEPTH) * MAX_AW'(STRBW);

  function automatic logic [1:0] burst_err(input logic [AW-1:0] addr, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
    logic [MAX_AW-1:0] a;
    a = MAX_AW'(addr);
    if (MAX_AW'(size) > MAX_AW'(OFFW))
      burst_err = SLVERR;
    else if (a >= MEM_BYTES || burst_hi(a, len, size, burst) >= MEM_BYTES)
      burst_err = DECERR;
    else
      burst_err = OKAY;
  endfunction

  assign w_aw_err = burst_err(axi_s.awaddr, axi_s.awlen, axi_s.awsize, axi_s.awburst);
  assign w_ar_err = burst_err(axi_s.araddr, axi_s.arlen, axi_s.arsize, axi_s.arburst);
`else
  assign w_aw_err = OKAY;
  assign w_ar_err = OKAY;
`endif

  axi4_burst_addr #(.AW(AW)) u_waddr (
    .i_clk         (clk_i),
    .i_rst         (rst_i),
    .i_load        (w_aw_hs),
    .i_addr        (axi_s.awaddr),
    .i_len         (axi_s.awlen),
    .i_size        (axi_s.awsize),
    .i_burst       (axi_s.awburst),
    .i_step        (w_w_hs),
    .o_addr        (w_waddr),
    .o_next_addr_c (w_wnext_addr),
    .o_last        (w_wlast_gen),
    .o_next_last_c (w_wnext_last)
  );

  axi4_burst_addr #(.AW(AW)) u_raddr (
    .i_clk         (clk_i),
    .i_rst         (rst_i),
    .i_load        (w_ar_hs),
    .i_addr        (axi_s.araddr),
    .i_len         (axi_s.arlen),
    .i_size        (axi_s.arsize),
    .i_burst       (axi_s.arburst),
    .i_step        (w_r_hs),
    .o_addr        (w_raddr),
    .o_next_addr_c (w_rnext_addr),
    .o_last        (w_rlast_gen),
    .o_next_last_c (w_rnext_last)
  );

  // Write FSM: the beat count, not WLAST, closes the burst.
  always_comb begin
    w_wstate_nxt    = r_wstate;
    w_beat_mismatch = w_w_hs && (axi_s.wlast != w_wlast_gen);
    w_bresp_nxt     = OKAY;
    if (r_w_err != OKAY)
      w_bresp_nxt = r_w_err;
    else if (r_wlast_err || w_beat_mismatch)
      w_bresp_nxt = SLVERR;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_wlast_gen) w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wstate    <= W_IDLE;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bid       <= '0;
      r_bresp     <= OKAY;
      r_wlast_err <= 1'b0;
      r_w_err     <= OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_aw_hs) begin
        r_bid       <= axi_s.awid;
        r_wlast_err <= 1'b0;
        r_w_err     <= w_aw_err;
      end else if (w_beat_mismatch) begin
        r_wlast_err <= 1'b1;
      end
      if (w_w_hs && w_wlast_gen)
        r_bresp <= w_bresp_nxt;
    end
  end

  assign w_mem_we = w_w_hs && (r_w_err == OKAY);

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < int'(STRBW); b++) begin
        if (axi_s.wstrb[b])
          r_mem[w_waddr[IDXW+OFFW-1:OFFW]][b*8 +: 8] <= axi_s.wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM: one burst at a time, ARREADY held low until the last beat is taken.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rresp   <= OKAY;
      r_r_err   <= OKAY;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      if (w_ar_hs) begin
        r_rid   <= axi_s.arid;
        r_rlast <= (axi_s.arlen == 8'd0);
        r_rresp <= w_ar_err;
        r_r_err <= w_ar_err;
      end else if (w_r_hs) begin
        r_rlast <= r_rlast ? 1'b0 : w_rnext_last;
      end
    end
  end

  // Data for the next beat loads on the same edge the current one is taken; old data wins a collision.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_rdata <= '0;
    else if (w_ar_hs)
      r_rdata <= (w_ar_err != OKAY) ? '0 : r_mem[axi_s.araddr[IDXW+OFFW-1:OFFW]];
    else if (w_r_hs && !r_rlast)
      r_rdata <= (r_r_err != OKAY) ? '0 : r_mem[w_rnext_addr[IDXW+OFFW-1:OFFW]];
  end

  assign axi_s.awready = r_awready;
  assign axi_s.wready  = r_wready;
  assign axi_s.bvalid  = r_bvalid;
  assign axi_s.bid     = r_bid;
  assign axi_s.bresp   = r_bresp;
  assign axi_s.arready = r_arready;
  assign axi_s.rvalid  = r_rvalid;
  assign axi_s.rlast   = r_rlast;
  assign axi_s.rid     = r_rid;
  assign axi_s.rresp   = r_rresp;
  assign axi_s.rdata   = r_rdata;

  assign w_unused = ^{axi_s.aclk, axi_s.aresetn, w_waddr, w_wnext_addr, w_wnext_last,
                      w_raddr, w_rlast_gen};

endmodule
